// File: rtl/ili9341_spi_rx.sv
// ILI9341 4-wire serial receiver: deframes bytes and decodes CASET/PASET/RAMWR into addressed RGB565 pixels.
// Optional window checking is enabled by defining ILI9341_RX_WINDOW_CHECK_EN.
module ili9341_spi_rx #(
   parameter int X_MAX = 239,
   parameter int Y_MAX = 319
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        cs,
   input  logic        dc,
   input  logic        din,
   output logic        cmd_valid,
   output logic [7:0]  cmd_byte,
   output logic        pix_valid,
   output logic [15:0] pix_data,
   output logic [8:0]  pix_x,
   output logic [8:0]  pix_y,
   output logic        in_ramwr,
   output logic        err
);

   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_CASET = 3'd1,
      ST_PASET = 3'd2,
      ST_RAMWR = 3'd3,
      ST_SKIP  = 3'd4
   } state_t;

   state_t      state_q, state_d;
   logic [2:0]  bit_cnt_q, bit_cnt_d;
   logic [6:0]  shift_q, shift_d;
   logic [2:0]  param_idx_q, param_idx_d;
   logic [23:0] hold_q, hold_d;
   logic        phase_q, phase_d;
   logic [7:0]  hi_q, hi_d;
   logic [8:0]  x_start_q, x_start_d, x_end_q, x_end_d;
   logic [8:0]  y_start_q, y_start_d, y_end_q, y_end_d;
   logic [8:0]  x_q, x_d, y_q, y_d;
   logic        cmd_valid_q, cmd_valid_d;
   logic [7:0]  cmd_byte_q, cmd_byte_d;
   logic        pix_valid_q, pix_valid_d;
   logic [15:0] pix_data_q, pix_data_d;
   logic [8:0]  pix_x_q, pix_x_d, pix_y_q, pix_y_d;
   logic        in_ramwr_q, in_ramwr_d;

   logic [7:0]  byte_s;
   logic        byte_done_s;
   logic [31:0] word_s;
   logic [15:0] start_s, end_s;

   assign byte_s      = {shift_q, din};
   assign byte_done_s = ~cs & (bit_cnt_q == 3'd7);
   assign word_s      = {hold_q, byte_s};
   assign start_s     = word_s[31:16];
   assign end_s       = word_s[15:0];

`ifdef ILI9341_RX_WINDOW_CHECK_EN
   logic err_q, err_d;

   function automatic logic win_bad(input logic [15:0] s, input logic [15:0] e, input logic [15:0] mx);
      return (s > e) || (e > mx) || (|s[15:9]) || (|e[15:9]);
   endfunction
`else
   logic unused_s;
   assign unused_s = ^{start_s[15:9], end_s[15:9]};
`endif

   // Deframer, command/parameter decoder and pixel address generator
   always_comb begin
      state_d     = state_q;
      bit_cnt_d   = bit_cnt_q;
      shift_d     = shift_q;
      param_idx_d = param_idx_q;
      hold_d      = hold_q;
      phase_d     = phase_q;
      hi_d        = hi_q;
      x_start_d   = x_start_q;
      x_end_d     = x_end_q;
      y_start_d   = y_start_q;
      y_end_d     = y_end_q;
      x_d         = x_q;
      y_d         = y_q;
      cmd_valid_d = 1'b0;
      cmd_byte_d  = cmd_byte_q;
      pix_valid_d = 1'b0;
      pix_data_d  = pix_data_q;
      pix_x_d     = pix_x_q;
      pix_y_d     = pix_y_q;
`ifdef ILI9341_RX_WINDOW_CHECK_EN
      err_d       = err_q;
`endif
      if (cs) begin
         bit_cnt_d = 3'd0;
      end else begin
         bit_cnt_d = bit_cnt_q + 3'd1;
         shift_d   = byte_s[6:0];
      end
      case ({byte_done_s, dc})
         2'b10: begin
            cmd_valid_d = 1'b1;
            cmd_byte_d  = byte_s;
            param_idx_d = 3'd0;
            phase_d     = 1'b0;
            case (byte_s)
               8'h2A:   state_d = ST_CASET;
               8'h2B:   state_d = ST_PASET;
               8'h2C: begin
                  state_d = ST_RAMWR;
                  x_d     = x_start_q;
                  y_d     = y_start_q;
               end
               default: state_d = ST_SKIP;
            endcase
         end
         2'b11: begin
            case (state_q)
               ST_CASET, ST_PASET: begin
                  case (param_idx_q)
                     3'd0, 3'd1, 3'd2: begin
                        hold_d      = {hold_q[15:0], byte_s};
                        param_idx_d = param_idx_q + 3'd1;
                     end
                     3'd3: begin
                        // Saturate at 4 so trailing parameters never re-commit
                        param_idx_d = 3'd4;
`ifdef ILI9341_RX_WINDOW_CHECK_EN
                        if (state_q == ST_CASET) begin
                           if (win_bad(start_s, end_s, 16'(X_MAX))) begin
                              err_d = 1'b1;
                           end else begin
                              x_start_d = start_s[8:0];
                              x_end_d   = end_s[8:0];
                           end
                        end else begin
                           if (win_bad(start_s, end_s, 16'(Y_MAX))) begin
                              err_d = 1'b1;
                           end else begin
                              y_start_d = start_s[8:0];
                              y_end_d   = end_s[8:0];
                           end
                        end
`else
                        if (state_q == ST_CASET) begin
                           x_start_d = start_s[8:0];
                           x_end_d   = end_s[8:0];
                        end else begin
                           y_start_d = start_s[8:0];
                           y_end_d   = end_s[8:0];
                        end
`endif
                     end
                     default: ;
                  endcase
               end
               ST_RAMWR: begin
                  if (!phase_q) begin
                     hi_d    = byte_s;
                     phase_d = 1'b1;
                  end else begin
                     phase_d     = 1'b0;
                     pix_valid_d = 1'b1;
                     pix_data_d  = {hi_q, byte_s};
                     pix_x_d     = x_q;
                     pix_y_d     = y_q;
                     if (x_q == x_end_q) begin
                        x_d = x_start_q;
                        y_d = (y_q == y_end_q) ? y_start_q : (y_q + 9'd1);
                     end else begin
                        x_d = x_q + 9'd1;
                     end
                  end
               end
               default: ;
            endcase
         end
         default: ;
      endcase
      in_ramwr_d = (state_d == ST_RAMWR);
   end

   // State and output registers
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= ST_IDLE;
         bit_cnt_q   <= 3'd0;
         shift_q     <= 7'd0;
         param_idx_q <= 3'd0;
         hold_q      <= 24'd0;
         phase_q     <= 1'b0;
         hi_q        <= 8'd0;
         x_start_q   <= 9'd0;
         x_end_q     <= 9'(X_MAX);
         y_start_q   <= 9'd0;
         y_end_q     <= 9'(Y_MAX);
         x_q         <= 9'd0;
         y_q         <= 9'd0;
         cmd_valid_q <= 1'b0;
         cmd_byte_q  <= 8'd0;
         pix_valid_q <= 1'b0;
         pix_data_q  <= 16'd0;
         pix_x_q     <= 9'd0;
         pix_y_q     <= 9'd0;
         in_ramwr_q  <= 1'b0;
`ifdef ILI9341_RX_WINDOW_CHECK_EN
         err_q       <= 1'b0;
`endif
      end else begin
         state_q     <= state_d;
         bit_cnt_q   <= bit_cnt_d;
         shift_q     <= shift_d;
         param_idx_q <= param_idx_d;
         hold_q      <= hold_d;
         phase_q     <= phase_d;
         hi_q        <= hi_d;
         x_start_q   <= x_start_d;
         x_end_q     <= x_end_d;
         y_start_q   <= y_start_d;
         y_end_q     <= y_end_d;
         x_q         <= x_d;
         y_q         <= y_d;
         cmd_valid_q <= cmd_valid_d;
         cmd_byte_q  <= cmd_byte_d;
         pix_valid_q <= pix_valid_d;
         pix_data_q  <= pix_data_d;
         pix_x_q     <= pix_x_d;
         pix_y_q     <= pix_y_d;
         in_ramwr_q  <= in_ramwr_d;
`ifdef ILI9341_RX_WINDOW_CHECK_EN
         err_q       <= err_d;
`endif
      end
   end

   assign cmd_valid = cmd_valid_q;
   assign cmd_byte  = cmd_byte_q;
   assign pix_valid = pix_valid_q;
   assign pix_data  = pix_data_q;
   assign pix_x     = pix_x_q;
   assign pix_y     = pix_y_q;
   assign in_ramwr  = in_ramwr_q;
`ifdef ILI9341_RX_WINDOW_CHECK_EN
   assign err = err_q;
`else
   assign err = 1'b0;
`endif

endmodule

// File: tb/tb_ili9341_spi_rx.sv
// Scoreboard bench for ili9341_spi_rx: expected commands/pixels are queued by the stimulus and popped by a monitor.
module tb_ili9341_spi_rx;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        cs  = 1'b1;
   logic        dc  = 1'b0;
   logic        din = 1'b0;
   logic        cmd_valid;
   logic [7:0]  cmd_byte;
   logic        pix_valid;
   logic [15:0] pix_data;
   logic [8:0]  pix_x, pix_y;
   logic        in_ramwr;
   logic        err;

   int checks = 0;
   int errors = 0;
   bit gap_mode = 1'b0;

   logic [7:0]  exp_cmd[$];
   logic [33:0] exp_pix[$];

   ili9341_spi_rx dut (
      .clk(clk), .rst(rst), .cs(cs), .dc(dc), .din(din),
      .cmd_valid(cmd_valid), .cmd_byte(cmd_byte),
      .pix_valid(pix_valid), .pix_data(pix_data), .pix_x(pix_x), .pix_y(pix_y),
      .in_ramwr(in_ramwr), .err(err)
   );

   always #5 clk = ~clk;

   task automatic chk(input string nm, input logic [47:0] act, input logic [47:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask

   // Monitor: pop and compare whenever the DUT presents a pulse
   always @(negedge clk) begin
      if (cmd_valid) begin
         if (exp_cmd.size() == 0) chk("cmd_unexpected", {40'd0, cmd_byte}, 48'hFFFF_FFFF_FFFF);
         else chk("cmd", {40'd0, cmd_byte}, {40'd0, exp_cmd.pop_front()});
      end
      if (pix_valid) begin
         if (exp_pix.size() == 0) chk("pix_unexpected", {14'd0, pix_data, pix_x, pix_y}, 48'hFFFF_FFFF_FFFF);
         else chk("pix", {14'd0, pix_data, pix_x, pix_y}, {14'd0, exp_pix.pop_front()});
      end
   end

   initial begin
      #2ms;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   task automatic send_byte(input logic d, input logic [7:0] b);
      for (int i = 7; i >= 0; i--) begin
         @(negedge clk);
         cs = 1'b0; dc = d; din = b[i];
      end
      if (gap_mode) begin
         @(negedge clk);
         cs = 1'b1;
      end
   endtask

   task automatic idle(input int n);
      repeat (n) begin
         @(negedge clk);
         cs = 1'b1;
      end
   endtask

   task automatic cmd(input logic [7:0] b);
      exp_cmd.push_back(b);
      send_byte(1'b0, b);
   endtask

   task automatic dat(input logic [7:0] b);
      send_byte(1'b1, b);
   endtask

   task automatic params(input logic [7:0] a, input logic [7:0] b, input logic [7:0] c, input logic [7:0] d);
      dat(a); dat(b); dat(c); dat(d);
   endtask

   task automatic pixel(input logic [15:0] d, input logic [8:0] x, input logic [8:0] y);
      exp_pix.push_back({d, x, y});
      dat(d[15:8]);
      dat(d[7:0]);
   endtask

   initial begin
      logic [15:0] pd;
      repeat (3) @(negedge clk);
      chk("reset_outputs", {2'd0, cmd_valid, cmd_byte, pix_valid, pix_data, pix_x, pix_y, in_ramwr, err}, 48'd0);
      rst = 1'b0;
      idle(2);

      // Windowed write with cs gaps between bytes
      gap_mode = 1'b1;
      cmd(8'h2A); params(8'h00, 8'h14, 8'h00, 8'hDB);
      cmd(8'h2B); params(8'h00, 8'h3C, 8'h01, 8'h03);
      cmd(8'h2C);
      chk("in_ramwr_rise", {47'd0, in_ramwr}, 48'd1);
      chk("cmd_byte_2c", {40'd0, cmd_byte}, 48'h2C);
      for (int n = 0; n < 201; n++) begin
         pd = 16'(n) ^ 16'hA5C3;
         pixel(pd, 9'(20 + (n % 200)), 9'(60 + (n / 200)));
      end

      // 2x2 window with wrap, back-to-back bytes
      gap_mode = 1'b0;
      cmd(8'h2A); params(8'h00, 8'h00, 8'h00, 8'h01);
      cmd(8'h2B); params(8'h00, 8'h00, 8'h00, 8'h01);
      cmd(8'h2C);
      pixel(16'hF800, 9'd0, 9'd0);
      pixel(16'h07E0, 9'd1, 9'd0);
      pixel(16'h001F, 9'd0, 9'd1);
      pixel(16'hFFFF, 9'd1, 9'd1);
      pixel(16'h0001, 9'd0, 9'd0);
      idle(1);

      // Partial byte aborted by cs, then unknown command -> SKIP
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         cs = 1'b0; dc = 1'b1; din = 1'b1;
      end
      idle(1);
      cmd(8'hA5);
      idle(1);
      chk("skip_in_ramwr", {47'd0, in_ramwr}, 48'd0);
      chk("cmd_byte_a5", {40'd0, cmd_byte}, 48'hA5);
      dat(8'h12); dat(8'h34);
      idle(1);

      // Short CASET keeps old window; pending hi byte dropped by a command
      cmd(8'h2A); params(8'h00, 8'h05, 8'h00, 8'h09);
      cmd(8'h2A); dat(8'h00); dat(8'h07);
      cmd(8'h2C);
      pixel(16'h1234, 9'd5, 9'd0);
      dat(8'hAB);
      cmd(8'h00);
      idle(1);
      chk("in_ramwr_fall", {47'd0, in_ramwr}, 48'd0);
      cmd(8'h2C);
      pixel(16'h5678, 9'd5, 9'd0);

      // Reversed and oversized windows
      cmd(8'h2A); params(8'h00, 8'hDB, 8'h00, 8'h14);
      idle(1);
`ifdef ILI9341_RX_WINDOW_CHECK_EN
      chk("err_reversed", {47'd0, err}, 48'd1);
      cmd(8'h2C);
      pixel(16'h0A0A, 9'd5, 9'd0);
      pixel(16'h0B0B, 9'd6, 9'd0);
`else
      chk("err_reversed", {47'd0, err}, 48'd0);
      cmd(8'h2C);
      pixel(16'h0A0A, 9'd219, 9'd0);
      pixel(16'h0B0B, 9'd220, 9'd0);
`endif
      cmd(8'h2A); params(8'h00, 8'h00, 8'h00, 8'hF0);
      idle(1);
`ifdef ILI9341_RX_WINDOW_CHECK_EN
      chk("err_oversize", {47'd0, err}, 48'd1);
      cmd(8'h2C);
      pixel(16'h0C0C, 9'd5, 9'd0);
`else
      chk("err_oversize", {47'd0, err}, 48'd0);
      cmd(8'h2C);
      pixel(16'h0C0C, 9'd0, 9'd0);
`endif

      // Reset in the middle of a pixel
      dat(8'h11);
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         cs = 1'b0; dc = 1'b1; din = 1'b1;
      end
      @(negedge clk);
      rst = 1'b1; cs = 1'b1;
      #1;
      chk("mid_reset_outputs", {2'd0, cmd_valid, cmd_byte, pix_valid, pix_data, pix_x, pix_y, in_ramwr, err}, 48'd0);
      @(negedge clk);
      rst = 1'b0;
      idle(1);
      cmd(8'h2C);
      for (int n = 0; n < 241; n++) begin
         pd = 16'(n) + 16'h0100;
         pixel(pd, (n < 240) ? 9'(n) : 9'd0, (n < 240) ? 9'd0 : 9'd1);
      end

      idle(4);
      chk("cmd_queue_drained", 48'(exp_cmd.size()), 48'd0);
      chk("pix_queue_drained", 48'(exp_pix.size()), 48'd0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
